ld_req_to_noc2_adapter: RTL and testbench
=========================================

Name: ld_req_to_noc2_adapter

Overview:
- Transmit-side counterpart of the load-unit NoC3 response path.
- Accepts load requests (line address + MSHR id) from the fifo_controller load unit over a valid/ready handshake.
- Buffers them in a small FIFO and serializes each into a 3-flit P-Mesh NoC2 LOAD_REQ packet on a valid/ready NoC2 output.
- Responses for these requests return via NoC3 carrying the same mshrid.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >=2)
ADDR_W, 40, physical address width
MSHRID_W, 8, MSHR id width
FLIT_W, 64, NoC flit width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous reset, active low
ld_req_valid_i  input  1  load request valid
ld_req_ready_o  output  1  request accepted when valid&&ready
ld_req_addr_i  input  ADDR_W  cacheline address (low 6 bits forced to 0 in packet)
ld_req_mshrid_i  input  MSHRID_W  MSHR id echoed in response
src_x_i  input  8  own tile X; quasi-static
src_y_i  input  8  own tile Y; quasi-static
dest_x_i  input  8  home tile X; quasi-static
dest_y_i  input  8  home tile Y; quasi-static
noc2_valid_o  output  1  flit valid
noc2_ready_i  input  1  flit accepted when valid&&ready
noc2_data_o  output  FLIT_W  flit payload
busy_o  output  1  FIFO non-empty or packet in flight

Behaviour:
- Reset: rst_n is synchronous and active low; clock is clk. Reset empties the FIFO and sets the FSM to S_IDLE. Outputs after reset: ld_req_ready_o=1, noc2_valid_o=0, noc2_data_o=0, busy_o=0.
- FIFO:
  - Push on ld_req_valid_i&&ld_req_ready_o; stores {addr, mshrid}.
  - ld_req_ready_o = !full. No combinational dependence on noc2_ready_i, so a full FIFO blocks even if a pop occurs that cycle.
  - Pop only on acceptance of the final flit.
  - Pointers wrap modulo DEPTH; count is width clog2(DEPTH)+1.
- FSM states: S_IDLE, S_HDR, S_ADDR, S_SRC.
  - S_IDLE -> S_HDR when the FIFO is non-empty.
  - S_HDR -> S_ADDR on noc2_ready_i.
  - S_ADDR -> S_SRC on noc2_ready_i.
  - S_SRC on noc2_ready_i: pop; go to S_HDR if the FIFO is non-empty after pop+push this cycle, else S_IDLE.
  - Back-to-back packets therefore have no bubble.
- noc2_valid_o = (state != S_IDLE). Flit content is driven from the FIFO head and the config ports.
- noc2_data_o must hold stable while valid&&!ready. noc2_data_o = 0 in S_IDLE.
- Flit 0 (header), S_HDR:
  - [63:50]=0 (dest chipid)
  - [49:42]=dest_x_i, [41:34]=dest_y_i
  - [33:30]=4'b0000 (fbits)
  - [29:22]=8'd2 (payload length)
  - [21:14]=8'd31 (LOAD_REQ)
  - [13:6]=mshrid, zero-extended/truncated to 8 bits
  - [5:0]=0
- Flit 1 (address), S_ADDR: [ADDR_W-1:6]=addr[ADDR_W-1:6], [5:0]=0, upper bits 0.
- Flit 2 (source), S_SRC: [63:50]=0, [49:42]=src_x_i, [41:34]=src_y_i, [33:0]=0.
- Latency: request accepted at edge N gives the header flit valid at cycle N+2 (FIFO registered, FSM registered).
- busy_o = (count != 0) || (state != S_IDLE).
- Reset mid-packet: packet abandoned, FIFO contents discarded, valid drops the cycle after the reset edge; no partial-packet recovery.
- noc2_ready_i asserted while noc2_valid_o=0: ignored.
- Config ports must be held constant while busy_o=1; behaviour is otherwise undefined.

Test Plan:
- Single request: addr=40'h12_3456_78C0, mshrid=8'h05, dest=(1,2), src=(3,4), noc2_ready_i=1 -> cycles N+2..N+4 emit three flits:
  - flit0: [49:42]=1, [41:34]=2, len=2, type=31, [13:6]=5
  - flit1: 40'h12_3456_78C0
  - flit2: [49:42]=3, [41:34]=4
  - then valid=0, busy_o=0.
- Back-pressure: hold noc2_ready_i=0 for 5 cycles in S_ADDR -> noc2_data_o constant and valid=1 throughout; flit2 follows one cycle after ready rises.
- Fill: noc2_ready_i=0, push 4 requests (ids 1-4) -> ld_req_ready_o=0 after the 4th; a 5th request is not accepted. Release ready -> 12 flits in order ids 1,2,3,4 with no idle cycles between packets.
- Simultaneous push and final-flit pop with count=1 -> FSM goes S_SRC->S_HDR directly; next header carries the new mshrid.
- Address low bits: addr=...3F -> flit1[5:0]=0.
- Reset asserted in S_ADDR with 2 queued -> next cycle valid=0, busy_o=0, ready=1. A new request after reset emits a clean 3-flit packet.

Source files
------------

// File: rtl/ld_req_to_noc2_adapter.sv
// Queues load requests and serializes each into a 3-flit NoC2 LOAD_REQ packet (hdr, addr, src).
// Latency: a request accepted at edge N presents its header flit after edge N+1; packets go back-to-back.
// Backpressure: flits hold while noc2_ready_i=0; ld_req_ready_o=!full, independent of noc2_ready_i.
module ld_req_to_noc2_adapter #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 40,
    parameter int MSHRID_W = 8,
    parameter int FLIT_W   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_req_valid_i,
    output logic                ld_req_ready_o,
    input  logic [ADDR_W-1:0]   ld_req_addr_i,
    input  logic [MSHRID_W-1:0] ld_req_mshrid_i,
    input  logic [7:0]          src_x_i,
    input  logic [7:0]          src_y_i,
    input  logic [7:0]          dest_x_i,
    input  logic [7:0]          dest_y_i,
    output logic                noc2_valid_o,
    input  logic                noc2_ready_i,
    output logic [FLIT_W-1:0]   noc2_data_o,
    output logic                busy_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(63);

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [MSHRID_W-1:0] mshrid;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_ADDR, S_SRC} state_t;

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    state_t           state;
    logic             full;
    logic             push;
    logic             pop;
    req_t             head;
    logic [7:0]       mshrid8;

    assign full           = (count == CNT_W'(DEPTH));
    assign ld_req_ready_o = !full;
    assign push           = ld_req_valid_i && !full;
    assign pop            = (state == S_SRC) && noc2_ready_i;
    assign head           = mem[rd_ptr];
    assign noc2_valid_o   = (state != S_IDLE);
    assign busy_o         = (count != '0) || (state != S_IDLE);

    generate
        if (MSHRID_W >= 8) begin : g_id_trunc
            assign mshrid8 = head.mshrid[7:0];
        end else begin : g_id_zext
            assign mshrid8 = {{(8-MSHRID_W){1'b0}}, head.mshrid};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: ld_req_addr_i, mshrid: ld_req_mshrid_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= S_IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
            case (state)
                S_IDLE: if (count != '0)  state <= S_HDR;
                S_HDR:  if (noc2_ready_i) state <= S_ADDR;
                S_ADDR: if (noc2_ready_i) state <= S_SRC;
                // Head is still counted here; another entry (or a same-cycle push) means no bubble.
                S_SRC:  if (noc2_ready_i) state <= (count > CNT_W'(1) || push) ? S_HDR : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        noc2_data_o = '0;
        case (state)
            S_HDR: begin
                noc2_data_o[49:42] = dest_x_i;
                noc2_data_o[41:34] = dest_y_i;
                noc2_data_o[29:22] = 8'd2;
                noc2_data_o[21:14] = 8'd31;
                noc2_data_o[13:6]  = mshrid8;
            end
            S_ADDR: noc2_data_o[ADDR_W-1:0] = head.addr & LINE_MASK;
            S_SRC: begin
                noc2_data_o[49:42] = src_x_i;
                noc2_data_o[41:34] = src_y_i;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ld_req_to_noc2_adapter.sv
// Directed and random stimulus for ld_req_to_noc2_adapter against a packet-level flit queue model.
module tb_ld_req_to_noc2_adapter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_req_valid_i;
    logic        ld_req_ready_o;
    logic [39:0] ld_req_addr_i;
    logic [7:0]  ld_req_mshrid_i;
    logic [7:0]  src_x_i, src_y_i, dest_x_i, dest_y_i;
    logic        noc2_valid_o;
    logic        noc2_ready_i;
    logic [63:0] noc2_data_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    ld_req_to_noc2_adapter #(.DEPTH(DEPTH), .ADDR_W(40), .MSHRID_W(8), .FLIT_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req_valid_i(ld_req_valid_i), .ld_req_ready_o(ld_req_ready_o),
        .ld_req_addr_i(ld_req_addr_i), .ld_req_mshrid_i(ld_req_mshrid_i),
        .src_x_i(src_x_i), .src_y_i(src_y_i), .dest_x_i(dest_x_i), .dest_y_i(dest_y_i),
        .noc2_valid_o(noc2_valid_o), .noc2_ready_i(noc2_ready_i),
        .noc2_data_o(noc2_data_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr_flit(input logic [7:0] dx, input logic [7:0] dy, input logic [7:0] id);
        return (64'(dx) << 42) | (64'(dy) << 34) | (64'd2 << 22) | (64'd31 << 14) | (64'(id) << 6);
    endfunction

    function automatic logic [63:0] addr_flit(input logic [39:0] a);
        return 64'(a) & ~64'h3F;
    endfunction

    function automatic logic [63:0] src_flit(input logic [7:0] sx, input logic [7:0] sy);
        return (64'(sx) << 42) | (64'(sy) << 34);
    endfunction

    // Reference: each accepted request enqueues its three flits; outstanding requests = ceil(flits/3).
    logic [63:0] exp_q[$];
    int          cnt = 0;
    int          prev_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cnt        = 0;
            prev_cnt   = 0;
            prev_stall = 1'b0;
        end else begin
            check1("mon_ready", ld_req_ready_o, cnt < DEPTH);
            check1("mon_busy", busy_o, cnt != 0);
            // Work becomes visible one cycle after it is first queued, then stays up until drained.
            check1("mon_valid", noc2_valid_o, (cnt != 0) && (prev_cnt != 0));
            if (!noc2_valid_o) check64("mon_idle_data", noc2_data_o, 64'd0);
            if (prev_stall) check64("mon_stable", noc2_data_o, prev_data);
            prev_cnt = cnt;
            if (noc2_valid_o && noc2_ready_i) begin
                check1("mon_flit_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check64("mon_flit", noc2_data_o, exp_q.pop_front());
                    if (exp_q.size() % 3 == 0) cnt--;
                end
            end
            if (ld_req_valid_i && ld_req_ready_o) begin
                exp_q.push_back(hdr_flit(dest_x_i, dest_y_i, ld_req_mshrid_i));
                exp_q.push_back(addr_flit(ld_req_addr_i));
                exp_q.push_back(src_flit(src_x_i, src_y_i));
                cnt++;
            end
            prev_stall = noc2_valid_o && !noc2_ready_i;
            prev_data  = noc2_data_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!noc2_valid_o && n < 50) begin tick(); n++; end
        check1("wait_valid", noc2_valid_o, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        noc2_ready_i = 1'b1;
        while (busy_o && n < 200) begin tick(); n++; end
        check1("drain_idle", busy_o, 1'b0);
    endtask

    task automatic push_req(input logic [39:0] a, input logic [7:0] id);
        ld_req_valid_i  = 1'b1;
        ld_req_addr_i   = a;
        ld_req_mshrid_i = id;
        tick();
        ld_req_valid_i  = 1'b0;
    endtask

    logic [63:0] held;

    initial begin
        rst_n = 1'b0; ld_req_valid_i = 1'b0; ld_req_addr_i = '0; ld_req_mshrid_i = '0;
        noc2_ready_i = 1'b0;
        src_x_i = 8'd3; src_y_i = 8'd4; dest_x_i = 8'd1; dest_y_i = 8'd2;
        repeat (3) tick();
        rst_n = 1'b1;
        check1("rst_ready", ld_req_ready_o, 1'b1);
        check1("rst_valid", noc2_valid_o, 1'b0);
        check64("rst_data", noc2_data_o, 64'd0);
        check1("rst_busy", busy_o, 1'b0);

        // Single request, ready always high
        noc2_ready_i = 1'b1;
        push_req(40'h12_3456_78C0, 8'h05);
        check1("single_lat_n", noc2_valid_o, 1'b0);
        tick();
        check1("single_hdr_vld", noc2_valid_o, 1'b1);
        check64("single_hdr_dx", 64'(noc2_data_o[49:42]), 64'd1);
        check64("single_hdr_dy", 64'(noc2_data_o[41:34]), 64'd2);
        check64("single_hdr_len", 64'(noc2_data_o[29:22]), 64'd2);
        check64("single_hdr_type", 64'(noc2_data_o[21:14]), 64'd31);
        check64("single_hdr_id", 64'(noc2_data_o[13:6]), 64'd5);
        tick();
        check64("single_addr", noc2_data_o, 64'h12_3456_78C0);
        tick();
        check64("single_src_x", 64'(noc2_data_o[49:42]), 64'd3);
        check64("single_src_y", 64'(noc2_data_o[41:34]), 64'd4);
        tick();
        check1("single_end_vld", noc2_valid_o, 1'b0);
        check1("single_end_busy", busy_o, 1'b0);

        // Back-pressure in S_ADDR
        noc2_ready_i = 1'b0;
        push_req(40'hAA_5555_0040, 8'h11);
        wait_valid();
        noc2_ready_i = 1'b1;
        tick();
        noc2_ready_i = 1'b0;
        held = noc2_data_o;
        check64("bp_in_addr", held, addr_flit(40'hAA_5555_0040));
        for (int i = 0; i < 5; i++) begin
            tick();
            check1("bp_valid", noc2_valid_o, 1'b1);
            check64("bp_hold", noc2_data_o, held);
        end
        noc2_ready_i = 1'b1;
        tick();
        check64("bp_src_after_ready", noc2_data_o, src_flit(8'd3, 8'd4));
        drain();

        // Fill the FIFO, then release
        noc2_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push_req(40'h10_0000_0000 + 40'(i * 64), 8'(i));
            check1("fill_ready", ld_req_ready_o, i < 4);
        end
        push_req(40'h10_0000_1000, 8'd5);
        check1("fill_5th_blocked", ld_req_ready_o, 1'b0);
        noc2_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check1("fill_no_bubble", noc2_valid_o, 1'b1);
            tick();
        end
        check1("fill_done", noc2_valid_o, 1'b0);
        drain();

        // Push coinciding with the final-flit pop at count=1
        noc2_ready_i = 1'b1;
        push_req(40'h01_0203_0400, 8'h21);
        repeat (3) tick();
        check64("pp_in_src", noc2_data_o, src_flit(8'd3, 8'd4));
        ld_req_valid_i = 1'b1; ld_req_addr_i = 40'h01_0203_0800; ld_req_mshrid_i = 8'h22;
        tick();
        ld_req_valid_i = 1'b0;
        check1("pp_hdr_vld", noc2_valid_o, 1'b1);
        check64("pp_hdr", noc2_data_o, hdr_flit(8'd1, 8'd2, 8'h22));
        drain();

        // Low address bits stripped, different tile coordinates
        dest_x_i = 8'hA5; dest_y_i = 8'h5A; src_x_i = 8'hFF; src_y_i = 8'h80;
        push_req(40'hAB_CDEF_013F, 8'hFE);
        wait_valid();
        check64("lowbits_hdr", noc2_data_o, hdr_flit(8'hA5, 8'h5A, 8'hFE));
        tick();
        check64("lowbits_bits", 64'(noc2_data_o[5:0]), 64'd0);
        check64("lowbits_addr", noc2_data_o, 64'hAB_CDEF_0100);
        drain();

        // Reset mid-packet with requests queued
        noc2_ready_i = 1'b0;
        push_req(40'h33_0000_0040, 8'd7);
        push_req(40'h33_0000_0080, 8'd8);
        push_req(40'h33_0000_00C0, 8'd9);
        wait_valid();
        noc2_ready_i = 1'b1;
        tick();
        noc2_ready_i = 1'b0;
        check64("rst_mid_in_addr", noc2_data_o, addr_flit(40'h33_0000_0040));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check1("rst_mid_valid", noc2_valid_o, 1'b0);
        check1("rst_mid_busy", busy_o, 1'b0);
        check1("rst_mid_ready", ld_req_ready_o, 1'b1);
        check64("rst_mid_data", noc2_data_o, 64'd0);
        noc2_ready_i = 1'b1;
        push_req(40'h44_0000_0FC0, 8'h3C);
        tick();
        check64("post_rst_hdr", noc2_data_o, hdr_flit(8'hA5, 8'h5A, 8'h3C));
        tick();
        check64("post_rst_addr", noc2_data_o, 64'h44_0000_0FC0);
        tick();
        check64("post_rst_src", noc2_data_o, src_flit(8'hFF, 8'h80));
        tick();
        check1("post_rst_idle", noc2_valid_o, 1'b0);

        // Random traffic with random back-pressure; config changes only while idle
        for (int r = 0; r < 3; r++) begin
            dest_x_i = 8'($urandom()); dest_y_i = 8'($urandom());
            src_x_i  = 8'($urandom()); src_y_i  = 8'($urandom());
            for (int i = 0; i < 300; i++) begin
                ld_req_valid_i  = ($urandom_range(0, 1) == 1);
                ld_req_addr_i   = 40'({$urandom(), $urandom()});
                ld_req_mshrid_i = 8'($urandom());
                noc2_ready_i    = ($urandom_range(0, 9) < 6);
                tick();
            end
            ld_req_valid_i = 1'b0;
            drain();
            tick();
            check64("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
